decode_fwd_regfile_pipe: RTL and testbench

//  Parametrised Y86-64 decode/write-back stage for the pipelined core.

---
 rtl/decode_fwd_regfile_pipe_if.sv | 34 +++
 rtl/decode_fwd_regfile_pipe.sv | 139 +++++++++++++
 tb/tb_decode_fwd_regfile_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_fwd_regfile_pipe_if.sv
// Decode-stage bus: D-register fields and forward sources in, E-register fields and stall out.
interface decode_fwd_regfile_pipe_if #(
    parameter int DW = 64,
    parameter int RW = 4
);
    logic [2:0]    D_stat;
    logic [3:0]    D_icode, D_ifun;
    logic [RW-1:0] D_rA, D_rB;
    logic [DW-1:0] D_valC, D_valP;
    logic [RW-1:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic          E_bubble_in;
    logic          d_stall;
    logic [2:0]    E_stat;
    logic [3:0]    E_icode, E_ifun;
    logic [DW-1:0] E_valC, E_valA, E_valB;
    logic [RW-1:0] E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
               e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
               W_dstE, W_valE, W_dstM, W_valM, E_bubble_in,
        input  d_stall, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
               e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
               W_dstE, W_valE, W_dstM, W_valM, E_bubble_in,
        output d_stall, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_fwd_regfile_pipe.sv
// Y86-64 decode/write-back: regfile, e/M/W forwarding, load-use stall and the D->E register.
// Optional DEC_PERF_CNT_EN adds saturating stall / forward-use counters.
module decode_fwd_regfile_pipe #(
    parameter int DW   = 64,
    parameter int RW   = 4,
    parameter int NREG = 16
) (
    input  logic clk,
    input  logic rst_n,
    decode_fwd_regfile_pipe_if.slave bus
`ifdef DEC_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_fwd_cnt
`endif
);
    localparam logic [RW-1:0] RNONE = '1;
    localparam logic [RW-1:0] RESP  = RW'(4);
    localparam int NPHYS = NREG - 1;
    localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8;
    localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;

    typedef struct packed {
        logic [2:0]    stat;
        logic [3:0]    icode, ifun;
        logic [DW-1:0] valC, valA, valB;
        logic [RW-1:0] dstE, dstM, srcA, srcB;
    } e_reg_t;

    localparam e_reg_t BUBBLE = '{stat: 3'd1, icode: I_NOP, ifun: 4'h0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

    logic [DW-1:0] rf [NPHYS];
    e_reg_t        e_q, e_d;
    logic [RW-1:0] src_a, src_b, dst_e, dst_m;
    logic [DW-1:0] val_a, val_b;
    logic          use_valp, stall;

    // IDs at or above NPHYS (including RNONE) have no storage and read as zero
    function automatic logic [DW-1:0] rf_read(input logic [RW-1:0] id);
        for (int i = 0; i < NPHYS; i++)
            if (id == RW'(i)) return rf[i];
        return '0;
    endfunction

    function automatic logic [DW-1:0] fwd_val(input logic [RW-1:0] src);
        if (src == RNONE)      return '0;
        if (src == bus.e_dstE) return bus.e_valE;
        if (src == bus.M_dstM) return bus.m_valM;
        if (src == bus.M_dstE) return bus.M_valE;
        if (src == bus.W_dstM) return bus.W_valM;
        if (src == bus.W_dstE) return bus.W_valE;
        return rf_read(src);
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.D_icode)
            I_RRMOVQ: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
            I_IRMOVQ: dst_e = bus.D_rB;
            I_RMMOVQ: begin src_a = bus.D_rA; src_b = bus.D_rB; end
            I_MRMOVQ: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
            I_OPQ:    begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
            I_CALL:   begin src_b = RESP; dst_e = RESP; end
            I_RET:    begin src_a = RESP; src_b = RESP; dst_e = RESP; end
            I_PUSHQ:  begin src_a = bus.D_rA; src_b = RESP; dst_e = RESP; end
            I_POPQ:   begin src_a = RESP; src_b = RESP; dst_e = RESP; dst_m = bus.D_rA; end
            default:  ;
        endcase
    end

    assign use_valp = (bus.D_icode == I_CALL) || (bus.D_icode == I_JXX);
    assign val_a    = use_valp ? bus.D_valP : fwd_val(src_a);
    assign val_b    = fwd_val(src_b);

    // Load-use: the load in E cannot forward its result until it reaches M
    assign stall = ((e_q.icode == I_MRMOVQ) || (e_q.icode == I_POPQ)) && (e_q.dstM != RNONE) &&
                   ((e_q.dstM == src_a) || (e_q.dstM == src_b));

    assign e_d = '{stat: bus.D_stat, icode: bus.D_icode, ifun: bus.D_ifun,
                   valC: bus.D_valC, valA: val_a, valB: val_b,
                   dstE: dst_e, dstM: dst_m, srcA: src_a, srcB: src_b};

    // valM is checked first so popq %rsp leaves the loaded value in rsp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPHYS; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NPHYS; i++) begin
                if (bus.W_dstM == RW'(i))      rf[i] <= bus.W_valM;
                else if (bus.W_dstE == RW'(i)) rf[i] <= bus.W_valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        e_q <= BUBBLE;
        else if (stall || bus.E_bubble_in) e_q <= BUBBLE;
        else                               e_q <= e_d;
    end

    assign bus.d_stall = stall;
    assign bus.E_stat  = e_q.stat;
    assign bus.E_icode = e_q.icode;
    assign bus.E_ifun  = e_q.ifun;
    assign bus.E_valC  = e_q.valC;
    assign bus.E_valA  = e_q.valA;
    assign bus.E_valB  = e_q.valB;
    assign bus.E_dstE  = e_q.dstE;
    assign bus.E_dstM  = e_q.dstM;
    assign bus.E_srcA  = e_q.srcA;
    assign bus.E_srcB  = e_q.srcB;

`ifdef DEC_PERF_CNT_EN
    function automatic logic fwd_hit(input logic [RW-1:0] src);
        return (src != RNONE) &&
               ((src == bus.e_dstE) || (src == bus.M_dstM) || (src == bus.M_dstE) ||
                (src == bus.W_dstM) || (src == bus.W_dstE));
    endfunction

    logic fwd_any;
    assign fwd_any = use_valp || fwd_hit(src_a) || fwd_hit(src_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1))  perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (fwd_any && (perf_fwd_cnt != '1))  perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_fwd_regfile_pipe.sv
// Bench for decode_fwd_regfile_pipe: directed vector table, hand sequences, random vs reference model.
module tb_decode_fwd_regfile_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_fwd_regfile_pipe_if #(.DW(64), .RW(4)) bus ();
`ifdef DEC_PERF_CNT_EN
    logic [31:0] psc, pfc;
`endif

    decode_fwd_regfile_pipe #(.DW(64), .RW(4), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef DEC_PERF_CNT_EN
        , .perf_stall_cnt(psc), .perf_fwd_cnt(pfc)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } ereg_t;

    ereg_t       m_e;
    logic [63:0] m_rf [16];
    int          m_stall, m_fwd;

    function automatic ereg_t m_bubble();
        ereg_t b;
        b = '{stat: 3'd1, icode: 4'd1, ifun: 4'd0, valC: 64'd0, valA: 64'd0, valB: 64'd0,
              dstE: 4'd15, dstM: 4'd15, srcA: 4'd15, srcB: 4'd15};
        return b;
    endfunction

    task automatic clear_inputs();
        bus.D_stat = 3'd1; bus.D_icode = 4'd1; bus.D_ifun = 4'd0;
        bus.D_rA = 4'd15; bus.D_rB = 4'd15; bus.D_valC = 64'd0; bus.D_valP = 64'd0;
        bus.e_dstE = 4'd15; bus.M_dstE = 4'd15; bus.M_dstM = 4'd15;
        bus.W_dstE = 4'd15; bus.W_dstM = 4'd15;
        bus.e_valE = 64'd0; bus.M_valE = 64'd0; bus.m_valM = 64'd0;
        bus.W_valE = 64'd0; bus.W_valM = 64'd0;
        bus.E_bubble_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_e = m_bubble();
        for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
        m_stall = 0;
        m_fwd = 0;
    endtask

    // Reference: sources/destinations straight from the instruction-class sets
    task automatic m_decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            output logic [3:0] sa, output logic [3:0] sb,
                            output logic [3:0] de, output logic [3:0] dm);
        sa = (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) ? ra : (ic inside {4'd9, 4'd11}) ? 4'd4 : 4'd15;
        sb = (ic inside {4'd4, 4'd5, 4'd6}) ? rb : (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'd15;
        de = (ic inside {4'd2, 4'd3, 4'd6}) ? rb : (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'd15;
        dm = (ic inside {4'd5, 4'd11}) ? ra : 4'd15;
    endtask

    // Reference: first match in a priority-ordered list of forward sources, else architectural state
    task automatic m_read(input logic [3:0] src, output logic [63:0] v, output bit hit);
        logic [3:0]  fd [5];
        logic [63:0] fv [5];
        fd = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        fv = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        hit = 1'b0;
        v = 64'd0;
        if (src != 4'd15) begin
            v = m_rf[src];
            for (int i = 4; i >= 0; i--)
                if (fd[i] == src) begin v = fv[i]; hit = 1'b1; end
        end
    endtask

    task automatic chk_e(input string tag);
        chk({tag, " stat"},  64'(bus.E_stat),  64'(m_e.stat));
        chk({tag, " icode"}, 64'(bus.E_icode), 64'(m_e.icode));
        chk({tag, " ifun"},  64'(bus.E_ifun),  64'(m_e.ifun));
        chk({tag, " valC"},  bus.E_valC, m_e.valC);
        chk({tag, " valA"},  bus.E_valA, m_e.valA);
        chk({tag, " valB"},  bus.E_valB, m_e.valB);
        chk({tag, " dstE"},  64'(bus.E_dstE), 64'(m_e.dstE));
        chk({tag, " dstM"},  64'(bus.E_dstM), 64'(m_e.dstM));
        chk({tag, " srcA"},  64'(bus.E_srcA), 64'(m_e.srcA));
        chk({tag, " srcB"},  64'(bus.E_srcB), 64'(m_e.srcB));
    endtask

    // One model-checked cycle; inputs already driven just after the previous rising edge
    task automatic rstep();
        ereg_t nx;
        logic [3:0] sa, sb, de, dm;
        logic [63:0] va, vb;
        bit ha, hb, st;
        @(negedge clk);
        m_decode(bus.D_icode, bus.D_rA, bus.D_rB, sa, sb, de, dm);
        m_read(sa, va, ha);
        m_read(sb, vb, hb);
        if (bus.D_icode inside {4'd7, 4'd8}) begin va = bus.D_valP; ha = 1'b1; end
        st = (m_e.icode inside {4'd5, 4'd11}) && (m_e.dstM != 4'd15) &&
             ((m_e.dstM == sa) || (m_e.dstM == sb));
        chk("rnd d_stall", 64'(bus.d_stall), 64'(st));
        if (st || bus.E_bubble_in) nx = m_bubble();
        else nx = '{stat: bus.D_stat, icode: bus.D_icode, ifun: bus.D_ifun, valC: bus.D_valC,
                    valA: va, valB: vb, dstE: de, dstM: dm, srcA: sa, srcB: sb};
        m_stall += int'(st);
        m_fwd += int'(ha || hb);
        @(posedge clk); #1;
        if (bus.W_dstE != 4'd15) m_rf[bus.W_dstE] = bus.W_valE;
        if (bus.W_dstM != 4'd15) m_rf[bus.W_dstM] = bus.W_valM;
        m_e = nx;
        chk_e("rnd");
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
    endfunction

    task automatic rand_inputs();
        bus.D_stat = 3'($urandom_range(1, 4));
        bus.D_icode = 4'($urandom_range(0, 11));
        bus.D_ifun = 4'($urandom_range(0, 6));
        bus.D_rA = rnd_reg(); bus.D_rB = rnd_reg();
        bus.D_valC = {$urandom, $urandom}; bus.D_valP = {$urandom, $urandom};
        bus.e_dstE = rnd_reg(); bus.M_dstE = rnd_reg(); bus.M_dstM = rnd_reg();
        bus.W_dstE = rnd_reg(); bus.W_dstM = rnd_reg();
        bus.e_valE = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
        bus.m_valM = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
        bus.W_valM = {$urandom, $urandom};
        bus.E_bubble_in = ($urandom_range(0, 7) == 0);
    endtask

    typedef struct {
        int ic, ra, rb; longint valp;
        int ed; longint ev; int mde; longint mve; int mdm; longint mvm;
        int wde; longint wve; int wdm; longint wvm; int bub;
        int x_ic; longint x_va, x_vb; int x_de, x_dm, x_sa, x_sb;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{6, 3, 5, 0,       3, 7, 5, 9, 15, 0, 15, 0, 15, 0,    0, 6, 7, 9, 5, 15, 3, 5};
        tbl[1]  = '{2, 2, 6, 0,       2, 7, 2, 9, 15, 0, 15, 0, 15, 0,    0, 2, 7, 0, 6, 15, 2, 15};
        tbl[2]  = '{8, 15, 15, 'h40,  15, 'h99, 15, 0, 15, 0, 15, 0, 15, 0, 0, 8, 'h40, 0, 4, 15, 15, 4};
        tbl[3]  = '{6, 1, 2, 0,       15, 0, 1, 12, 1, 11, 2, 22, 2, 21,  0, 6, 11, 21, 2, 15, 1, 2};
        tbl[4]  = '{3, 15, 6, 0,      15, 'h99, 15, 0, 15, 0, 15, 0, 15, 0, 0, 3, 0, 0, 6, 15, 15, 15};
        tbl[5]  = '{11, 3, 15, 0,     15, 0, 15, 0, 15, 0, 4, 8, 15, 0,   0, 11, 8, 8, 4, 3, 4, 4};
        tbl[6]  = '{7, 15, 15, 'h1234, 15, 0, 15, 5, 15, 0, 15, 0, 15, 0, 0, 7, 'h1234, 0, 15, 15, 15, 15};
        tbl[7]  = '{5, 7, 8, 0,       15, 0, 15, 0, 15, 0, 8, 5, 15, 0,   0, 5, 0, 5, 15, 7, 15, 8};
        tbl[8]  = '{6, 3, 3, 0,       3, 7, 15, 0, 15, 0, 15, 0, 15, 0,   1, 1, 0, 0, 15, 15, 15, 15};
        tbl[9]  = '{10, 9, 15, 0,     4, 'h88, 15, 0, 15, 0, 9, 'h77, 15, 0, 0, 10, 'h77, 'h88, 4, 15, 9, 4};
        tbl[10] = '{6, 5, 6, 0,       6, 4, 5, 2, 15, 0, 5, 1, 6, 3,     0, 6, 2, 4, 6, 15, 5, 6};

        do_reset();
        chk("reset icode", 64'(bus.E_icode), 64'd1);
        chk("reset stat",  64'(bus.E_stat),  64'd1);
        chk("reset dstE",  64'(bus.E_dstE),  64'd15);
        chk("reset srcA",  64'(bus.E_srcA),  64'd15);
        chk("reset valA",  bus.E_valA, 64'd0);
        chk("reset stall", 64'(bus.d_stall), 64'd0);

        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            do_reset();
            bus.D_icode = 4'(tbl[i].ic); bus.D_rA = 4'(tbl[i].ra); bus.D_rB = 4'(tbl[i].rb);
            bus.D_valP = tbl[i].valp;
            bus.e_dstE = 4'(tbl[i].ed);  bus.e_valE = tbl[i].ev;
            bus.M_dstE = 4'(tbl[i].mde); bus.M_valE = tbl[i].mve;
            bus.M_dstM = 4'(tbl[i].mdm); bus.m_valM = tbl[i].mvm;
            bus.W_dstE = 4'(tbl[i].wde); bus.W_valE = tbl[i].wve;
            bus.W_dstM = 4'(tbl[i].wdm); bus.W_valM = tbl[i].wvm;
            bus.E_bubble_in = (tbl[i].bub != 0);
            @(negedge clk);
            chk({t, " stall"}, 64'(bus.d_stall), 64'd0);
            @(posedge clk); #1;
            chk({t, " icode"}, 64'(bus.E_icode), 64'(tbl[i].x_ic));
            chk({t, " valA"},  bus.E_valA, tbl[i].x_va);
            chk({t, " valB"},  bus.E_valB, tbl[i].x_vb);
            chk({t, " dstE"},  64'(bus.E_dstE), 64'(tbl[i].x_de));
            chk({t, " dstM"},  64'(bus.E_dstM), 64'(tbl[i].x_dm));
            chk({t, " srcA"},  64'(bus.E_srcA), 64'(tbl[i].x_sa));
            chk({t, " srcB"},  64'(bus.E_srcB), 64'(tbl[i].x_sb));
        end

        // Regfile write, then read back with no forwards active
        do_reset();
        bus.W_dstE = 4'd3; bus.W_valE = 64'd55;
        @(posedge clk); #1;
        clear_inputs();
        bus.D_icode = 4'd6; bus.D_rA = 4'd3; bus.D_rB = 4'd3;
        @(posedge clk); #1;
        chk("wb valA", bus.E_valA, 64'd55);
        chk("wb valB", bus.E_valB, 64'd55);
        chk("wb dstE", 64'(bus.E_dstE), 64'd3);

        // Same-register dual write: valM lands
        do_reset();
        bus.W_dstE = 4'd4; bus.W_valE = 64'd100; bus.W_dstM = 4'd4; bus.W_valM = 64'd200;
        @(posedge clk); #1;
        clear_inputs();
        bus.D_icode = 4'd6; bus.D_rA = 4'd4; bus.D_rB = 4'd2;
        @(posedge clk); #1;
        chk("dualwr valA", bus.E_valA, 64'd200);

        // Load-use stall, then stall coinciding with an external bubble
        do_reset();
        bus.D_icode = 4'd5; bus.D_rA = 4'd1; bus.D_rB = 4'd2;
        @(posedge clk); #1;
        chk("lu E dstM", 64'(bus.E_dstM), 64'd1);
        bus.D_icode = 4'd6; bus.D_rA = 4'd1; bus.D_rB = 4'd2;
        #1 chk("lu stall", 64'(bus.d_stall), 64'd1);
        @(posedge clk); #1;
        chk("lu bubble icode", 64'(bus.E_icode), 64'd1);
        chk("lu bubble dstE",  64'(bus.E_dstE), 64'd15);
        chk("lu stall clears", 64'(bus.d_stall), 64'd0);
        bus.D_icode = 4'd5; bus.D_rA = 4'd1; bus.D_rB = 4'd2;
        @(posedge clk); #1;
        bus.D_icode = 4'd6; bus.D_rA = 4'd1; bus.D_rB = 4'd2; bus.E_bubble_in = 1'b1;
        #1 chk("lu+bub stall", 64'(bus.d_stall), 64'd1);
        @(posedge clk); #1;
        chk("lu+bub icode", 64'(bus.E_icode), 64'd1);
        bus.E_bubble_in = 1'b0;
        #1 chk("lu+bub no stall", 64'(bus.d_stall), 64'd0);
        @(posedge clk); #1;
        chk("lu+bub single", 64'(bus.E_icode), 64'd6);
        chk("lu+bub dstE",   64'(bus.E_dstE), 64'd2);

        // Async reset mid-stream with OPQ in E
        do_reset();
        bus.D_icode = 4'd6; bus.D_rA = 4'd5; bus.D_rB = 4'd5;
        bus.W_dstE = 4'd5; bus.W_valE = 64'h55;
        @(posedge clk); #1;
        chk("mid W fwd valA", bus.E_valA, 64'h55);
        bus.W_dstE = 4'd15; bus.D_rB = 4'd6;
        @(posedge clk); #1;
        chk("mid rf valA", bus.E_valA, 64'h55);
        chk("mid icode",   64'(bus.E_icode), 64'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("async icode", 64'(bus.E_icode), 64'd1);
        chk("async valA",  bus.E_valA, 64'd0);
        chk("async dstE",  64'(bus.E_dstE), 64'd15);
`ifdef DEC_PERF_CNT_EN
        chk("async perf stall", 64'(psc), 64'd0);
        chk("async perf fwd",   64'(pfc), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset rf", bus.E_valA, 64'd0);

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            rstep();
        end
`ifdef DEC_PERF_CNT_EN
        chk("perf stall cnt", 64'(psc), 64'(m_stall));
        chk("perf fwd cnt",   64'(pfc), 64'(m_fwd));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
